// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the seven-segment scroll sequencer.
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    MODE_SHOW   = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DIGITS_SHOWN = 6;

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// Key, speed, message-write and display signals of the scroll sequencer.
interface hex_scroll_ctrl_if;
  logic [1:0]  key;
  logic [1:0]  speed_sel;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [3:0]  wr_val;
  logic [23:0] digits;
  logic [1:0]  mode;
  logic        dir;

  modport master (
    output key, speed_sel, wr_en, wr_idx, wr_val,
    input  digits, mode, dir
  );

  modport slave (
    input  key, speed_sel, wr_en, wr_idx, wr_val,
    output digits, mode, dir
  );
endinterface

// File: rtl/hex_scroll_ctrl_key_debounce.sv
// One push key: 2-flop synchronizer, debounce counter, press pulse on 1->0.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + CW'(1);
    end
  end

  // Pulse in the cycle the accepted level is about to fall, so the consumer
  // registers the event on the same edge that the level flips.
  assign press_o = level_q & ~level_d;

  // Synchronizer, accepted level and debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Six-digit seven-segment sequencer: static or circularly scrolled nibble message.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int unsigned         DEPTH      = 8,
  parameter logic [4*DEPTH-1:0]  INIT_MSG   = 32'h0123_4567,
  parameter int unsigned         TICK_DIV   = 12_500_000,
  parameter int unsigned         DEB_CYCLES = 500_000
) (
  input logic               clk,
  input logic               rst_n,
  hex_scroll_ctrl_if.slave  bus
);

  localparam int unsigned OW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TICK_DIV * 8 + 1);
  localparam int unsigned DW = 4 * DIGITS_SHOWN;

  mode_e         mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [PW-1:0] presc_q, presc_d, period_m1;
  logic [1:0]    speed_q;
  logic [3:0]    msg_q [DEPTH];
  logic [3:0]    msg_d [DEPTH];
  logic [DW-1:0] digits_q, digits_d;
  logic [OW:0]   idx;
  logic          press0, press1, speed_chg, tick;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.key[0]), .press_o(press0)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
    .clk(clk), .rst_n(rst_n), .key_raw(bus.key[1]), .press_o(press1)
  );

  // Mode FSM, direction, scroll offset and prescaler next-state.
  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    offset_d  = offset_q;
    presc_d   = '0;
    period_m1 = (PW'(TICK_DIV) << bus.speed_sel) - PW'(1);
    speed_chg = (bus.speed_sel != speed_q);
    tick      = (mode_q == MODE_SCROLL) && !speed_chg && (presc_q == period_m1);

    if ((mode_q == MODE_SCROLL) && !speed_chg && !tick) presc_d = presc_q + PW'(1);

    // Tick consumes the current dir; a same-cycle dir toggle lands afterwards.
    if (tick) begin
      if (dir_q == DIR_LEFT)
        offset_d = (offset_q == OW'(DEPTH - 1)) ? '0 : offset_q + OW'(1);
      else
        offset_d = (offset_q == '0) ? OW'(DEPTH - 1) : offset_q - OW'(1);
    end

    if (press0 && press1) begin
      mode_d   = MODE_SHOW;
      offset_d = '0;
      presc_d  = '0;
    end else if (press0) begin
      presc_d = '0;
      case (mode_q)
        MODE_SHOW:   mode_d = MODE_SCROLL;
        MODE_SCROLL: begin
          mode_d   = MODE_HOLD;
          offset_d = offset_q;
        end
        MODE_HOLD:   mode_d = MODE_SCROLL;
        default: begin
          mode_d   = MODE_SHOW;
          offset_d = '0;
        end
      endcase
    end else if (press1) begin
      dir_d = ~dir_q;
    end
  end

  // Message write port; out-of-range indices are dropped.
  always_comb begin
    msg_d = msg_q;
    if (bus.wr_en && ({1'b0, bus.wr_idx} < 5'(DEPTH)))
      msg_d[bus.wr_idx[OW-1:0]] = bus.wr_val;
  end

  // Window of six message nibbles starting at offset, hex5 first.
  always_comb begin
    digits_d = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DIGITS_SHOWN; i++) begin
      idx = {1'b0, offset_q} + (OW+1)'(i);
      if (idx >= (OW+1)'(DEPTH)) idx = idx - (OW+1)'(DEPTH);
      digits_d[4*(DIGITS_SHOWN-1-i) +: 4] = msg_q[idx[OW-1:0]];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_SHOW;
      dir_q    <= DIR_LEFT;
      offset_q <= '0;
      presc_q  <= '0;
      speed_q  <= '0;
      digits_q <= INIT_MSG[4*DEPTH-1 -: DW];
      for (int unsigned i = 0; i < DEPTH; i++)
        msg_q[i] <= INIT_MSG[4*(DEPTH-1-i) +: 4];
    end else begin
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      offset_q <= offset_d;
      presc_q  <= presc_d;
      speed_q  <= bus.speed_sel;
      digits_q <= digits_d;
      msg_q    <= msg_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.mode   = mode_q;
  assign bus.dir    = dir_q;

endmodule
